// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//   Producer-side scoreboard that sits beside the ID stage. For every GPR it
//   tracks how many cycles remain until an in-flight result becomes
//   forwardable (ME ALU result / WB write data). It raises a combinational
//   stall when an operand cannot yet be forwarded, or when a younger write
//   would complete before an older one to the same register (WAW).
//
//   The most recently issued write is remembered for one cycle, so that an EX
//   flush of that instruction can restore the older producer's countdown.
//
//   Optional feature macro: SB_LONG_OP_EN
//     defined   : id_lat all-ones marks a variable-latency op. Its entry holds
//                 (does not count down) until wb_done names its register.
//     undefined : wb_done/wb_done_addr are absent. All-ones id_lat is an
//                 ordinary countdown of 2**LAT_W-1 cycles.
//
// Parameters
//   LAT_W         width of each per-register countdown
//
// Ports
//   clk           pipeline clock
//   rst           asynchronous reset, active-high
//   id_valid      ID holds a valid instruction
//   id_rs         source register 1 address
//   id_rs_used    instruction reads rs
//   id_rt         source register 2 address
//   id_rt_used    instruction reads rt
//   id_wen        instruction writes a GPR
//   id_waddr      destination register
//   id_lat        cycles after issue until the result is forwardable
//   ex_flush      squash the instruction issued in the previous cycle
//   wb_done       (SB_LONG_OP_EN) variable-latency unit completed
//   wb_done_addr  (SB_LONG_OP_EN) destination of the completed op
//   stall         hold ID/IF this cycle (combinational)
//   sb_busy       bit i set while register i has a pending countdown
// -----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic             id_rs_used,
  input  logic [4:0]       id_rt,
  input  logic             id_rt_used,
  input  logic             id_wen,
  input  logic [4:0]       id_waddr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             ex_flush,
`ifdef SB_LONG_OP_EN
  input  logic             wb_done,
  input  logic [4:0]       wb_done_addr,
`endif
  output logic             stall,
  output logic [31:0]      sb_busy
);

  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);
`ifdef SB_LONG_OP_EN
  localparam logic [LAT_W-1:0] LAT_MAX = '1;
`endif

  // Entry 0 exists only so that indexing by a raw 5-bit address is safe; it is
  // never written and stays zero, so $0 can never stall or show as busy.
  logic [LAT_W-1:0] cnt     [32];
  logic [LAT_W-1:0] cnt_nxt [32];

  logic             last_v;
  logic [4:0]       last_addr;
  logic [LAT_W-1:0] last_prev;

  logic             hazard_rs;
  logic             hazard_rt;
  logic             waw;
  logic             issue;
  logic [LAT_W-1:0] restore_val;

  // ---------------------------------------------------------------------------
  // Hazard detection and issue qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard_rs = id_rs_used && (id_rs != 5'd0) && (cnt[id_rs] != '0);
    hazard_rt = id_rt_used && (id_rt != 5'd0) && (cnt[id_rt] != '0);
    // An older write still counting down past the new one's latency would
    // land after it and leave a stale value in the register.
    waw       = id_wen && (id_waddr != 5'd0) && (cnt[id_waddr] > id_lat);
    stall     = id_valid && (hazard_rs || hazard_rt || waw);
    issue     = id_valid && !stall && !ex_flush && id_wen && (id_waddr != 5'd0);
  end

  // The flushed instruction's older producer resumes as if it had kept
  // counting through the cycle it was overwritten.
  assign restore_val = (last_prev != '0) ? last_prev - ONE : '0;

  // ---------------------------------------------------------------------------
  // Next-state for every countdown entry. Priority (highest last):
  // decrement/hold, write-back completion, flush restore, new issue.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every element gets a value before any conditional override, so no
    // path leaves cnt_nxt unassigned and no latch is inferred.
    cnt_nxt[0] = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_nxt[i] = (cnt[i] != '0) ? cnt[i] - ONE : '0;
`ifdef SB_LONG_OP_EN
      if (cnt[i] == LAT_MAX)
        cnt_nxt[i] = cnt[i];
      if (wb_done && (wb_done_addr == 5'(i)))
        cnt_nxt[i] = '0;
`endif
      if (ex_flush && last_v && (last_addr == 5'(i)))
        cnt_nxt[i] = restore_val;
      if (issue && (id_waddr == 5'(i)))
        cnt_nxt[i] = id_lat;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this small array is flops, not RAM, so it is cleared by reset;
      // a mid-operation reset must drop every pending countdown at once.
      for (int i = 0; i < 32; i++)
        cnt[i] <= '0;
      last_v    <= 1'b0;
      last_addr <= 5'd0;
      last_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      for (int i = 0; i < 32; i++)
        cnt[i] <= cnt_nxt[i];
      last_v <= issue;
      if (issue) begin
        last_addr <= id_waddr;
        last_prev <= cnt[id_waddr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered busy view
  // ---------------------------------------------------------------------------
  always_comb begin
    sb_busy = '0;
    for (int i = 1; i < 32; i++)
      sb_busy[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//   Self-checking bench for reg_scoreboard (LAT_W = 3). A table of
//   {inputs, expected stall, expected sb_busy} records is applied one cycle per
//   record; the expectation is queued when the stimulus is driven and popped
//   and compared on the following falling edge. Hand-written sequences cover
//   reset in mid-operation and the maximum / variable latency cases.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int LAT_W = 3;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic             id_rs_used;
  logic [4:0]       id_rt;
  logic             id_rt_used;
  logic             id_wen;
  logic [4:0]       id_waddr;
  logic [LAT_W-1:0] id_lat;
  logic             ex_flush;
  logic             wb_done;
  logic [4:0]       wb_done_addr;
  logic             stall;
  logic [31:0]      sb_busy;

  typedef struct {
    logic             valid;
    logic [4:0]       rs;
    logic             rs_used;
    logic [4:0]       rt;
    logic             rt_used;
    logic             wen;
    logic [4:0]       waddr;
    logic [LAT_W-1:0] lat;
    logic             flush;
    logic             exp_stall;
    logic [31:0]      exp_busy;
  } vec_t;

  typedef struct {
    logic        exp_stall;
    logic [31:0] exp_busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  reg_scoreboard #(.LAT_W(LAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rt        (id_rt),
    .id_rt_used   (id_rt_used),
    .id_wen       (id_wen),
    .id_waddr     (id_waddr),
    .id_lat       (id_lat),
    .ex_flush     (ex_flush),
`ifdef SB_LONG_OP_EN
    .wb_done      (wb_done),
    .wb_done_addr (wb_done_addr),
`endif
    .stall        (stall),
    .sb_busy      (sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic rsu,
                              input logic [4:0] rt, input logic rtu, input logic wen,
                              input logic [4:0] wa, input logic [LAT_W-1:0] lat,
                              input logic fl, input logic es, input logic [31:0] eb);
    vec_t r;
    r.valid = v;  r.rs = rs; r.rs_used = rsu; r.rt = rt; r.rt_used = rtu;
    r.wen = wen;  r.waddr = wa; r.lat = lat; r.flush = fl;
    r.exp_stall = es; r.exp_busy = eb;
    return r;
  endfunction

  // Shorthands: plain issue, plain rs read, idle.
  function automatic vec_t iss(input logic [4:0] wa, input logic [LAT_W-1:0] lat,
                               input logic es, input logic [31:0] eb);
    return mk(1, 0, 0, 0, 0, 1, wa, lat, 0, es, eb);
  endfunction

  function automatic vec_t rd(input logic [4:0] rs, input logic es, input logic [31:0] eb);
    return mk(1, rs, 1, 0, 0, 0, 0, 0, 0, es, eb);
  endfunction

  function automatic vec_t idle(input logic [31:0] eb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
  endfunction

  // Called just after a rising edge: drive, queue the expectation, compare on
  // the falling edge, then move to just after the next rising edge.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    id_valid   = v.valid;
    id_rs      = v.rs;
    id_rs_used = v.rs_used;
    id_rt      = v.rt;
    id_rt_used = v.rt_used;
    id_wen     = v.wen;
    id_waddr   = v.waddr;
    id_lat     = v.lat;
    ex_flush   = v.flush;
    e.exp_stall = v.exp_stall;
    e.exp_busy  = v.exp_busy;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check({name, " stall"}, {31'd0, stall}, {31'd0, got.exp_stall});
    check({name, " busy"},  sb_busy,        got.exp_busy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_done = 1'b0;
    wb_done_addr = 5'd0;
    step(idle(32'h0), "in_reset");

    // ---- stimulus table -------------------------------------------------
    // load-use: lat=1 stalls exactly one cycle
    vecs.push_back(idle(32'h0));
    vecs.push_back(iss(5, 1, 0, 32'h0));
    vecs.push_back(rd(5, 1, 32'h0000_0020));
    vecs.push_back(rd(5, 0, 32'h0));
    // $0 never tracked
    vecs.push_back(iss(0, 3, 0, 32'h0));
    vecs.push_back(rd(0, 0, 32'h0));
    // WAW: cnt[7]=2 blocks lat=1 write, accepted once cnt=1
    vecs.push_back(iss(7, 3, 0, 32'h0));
    vecs.push_back(idle(32'h0000_0080));
    vecs.push_back(iss(7, 1, 1, 32'h0000_0080));
    vecs.push_back(iss(7, 1, 0, 32'h0000_0080));
    vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 32'h0000_0080));
    // flush with no older producer: entry returns to zero
    vecs.push_back(iss(9, 2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0200));
    vecs.push_back(rd(9, 0, 32'h0));
    // flush with older producer (cnt=3) restores 2, then counts down
    vecs.push_back(iss(9, 3, 0, 32'h0));
    vecs.push_back(iss(9, 3, 0, 32'h0000_0200));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0200));
    vecs.push_back(idle(32'h0000_0200));
    vecs.push_back(idle(32'h0000_0200));
    vecs.push_back(idle(32'h0));
    // flush with nothing remembered; issue attempt during flush is dropped
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4, 2, 1, 0, 32'h0));
    vecs.push_back(rd(4, 0, 32'h0));
    // stalled instruction does not issue; rt hazard; unused rs ignored
    vecs.push_back(iss(6, 4, 0, 32'h0));
    vecs.push_back(mk(1, 6, 1, 0, 0, 1, 10, 2, 0, 1, 32'h0000_0040));
    vecs.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 32'h0000_0040));
    vecs.push_back(mk(1, 6, 1, 10, 1, 0, 0, 0, 0, 1, 32'h0000_0040));
    vecs.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0040));
    // invalid instruction never stalls
    vecs.push_back(iss(8, 2, 0, 32'h0));
    vecs.push_back(mk(0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0100));
    vecs.push_back(idle(32'h0000_0100));
    // lat=0: forwardable at once, never busy
    vecs.push_back(iss(11, 0, 0, 32'h0));
    vecs.push_back(rd(11, 0, 32'h0));
    // lat=6 on $31: busy for six cycles
    vecs.push_back(iss(31, 6, 0, 32'h0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(idle(32'h8000_0000));
    vecs.push_back(idle(32'h0));

    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k], $sformatf("vec%0d", k));

    // ---- reset in mid-operation --------------------------------------
    step(iss(3, 3, 0, 32'h0), "rst_issue");
    id_valid = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1; id_wen = 1'b0;
    #1;
    check("rst_pre stall", {31'd0, stall}, 32'd1);
    check("rst_pre busy", sb_busy, 32'h0000_0008);
    #1;
    rst = 1'b1;
    #1;
    check("rst_now stall", {31'd0, stall}, 32'd0);
    check("rst_now busy", sb_busy, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(rd(3, 0, 32'h0), "rst_after");
    step(idle(32'h0), "rst_after2");

`ifdef SB_LONG_OP_EN
    // ---- variable latency: hold until wb_done, issue beats wb_done -----
    step(iss(12, 7, 0, 32'h0), "long_issue");
    for (int k = 0; k < 20; k++)
      step(rd(12, 1, 32'h0000_1000), $sformatf("long_hold%0d", k));
    wb_done = 1'b1; wb_done_addr = 5'd12;
    step(idle(32'h0000_1000), "long_done");
    wb_done = 1'b0;
    step(rd(12, 0, 32'h0), "long_free");
    step(iss(13, 7, 0, 32'h0), "race_issue");
    wb_done = 1'b1; wb_done_addr = 5'd13;
    step(iss(13, 7, 0, 32'h0000_2000), "race_both");
    wb_done = 1'b0;
    step(idle(32'h0000_2000), "race_kept1");
    step(idle(32'h0000_2000), "race_kept2");
    wb_done = 1'b1;
    step(idle(32'h0000_2000), "race_done");
    wb_done = 1'b0;
    step(idle(32'h0), "race_free");
`else
    // ---- all-ones latency is an ordinary seven-cycle countdown ---------
    step(iss(12, 7, 0, 32'h0), "max_issue");
    for (int k = 0; k < 7; k++)
      step(rd(12, 1, 32'h0000_1000), $sformatf("max_busy%0d", k));
    step(rd(12, 0, 32'h0), "max_free");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
